// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller: register addresses,
// source indices, vector layout and the FSM state type.
package intc_pkg;

    localparam logic [15:0] INTC_ADDR_IF = 16'hFF0F;
    localparam logic [15:0] INTC_ADDR_IE = 16'hFFFF;

    localparam int unsigned SRC_VBLANK = 0;
    localparam int unsigned SRC_STAT   = 1;
    localparam int unsigned SRC_TIMER  = 2;
    localparam int unsigned SRC_SERIAL = 3;
    localparam int unsigned SRC_JOYPAD = 4;

    localparam logic [7:0]  VEC_BASE   = 8'h40;
    localparam int unsigned VEC_STRIDE = 8;

    typedef enum logic [1:0] {
        StIdle,
        StPend,
        StAck
    } intc_state_t;

    // Vector address for a given source index.
    function automatic logic [7:0] intc_vec(input int unsigned idx);
        return VEC_BASE + 8'(idx * VEC_STRIDE);
    endfunction

endpackage

// File: rtl/intc_prio_enc.sv
// Fixed-priority encoder: lowest set index of the pending vector wins.
module intc_prio_enc
    import intc_pkg::*;
#(
    parameter int unsigned NUM_SRC = 5,
    localparam int unsigned IdxW   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [NUM_SRC-1:0] pend,
    output logic               valid,
    output logic [IdxW-1:0]    idx,
    output logic [7:0]         vec
);

    // Scan from the top so the lowest set index is the last one written.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pend[i]) begin
                valid = 1'b1;
                idx   = IdxW'(i);
            end
        end
        vec = intc_vec(32'(idx));
    end

endmodule

// File: rtl/intc.sv
// Interrupt controller: holds IF/IE, latches peripheral requests, arbitrates
// and hands a single request plus vector to the CPU.
// Build option: INTC_EDGE_DETECT_EN makes requests latch on 0->1 transitions
// only; without it every high cycle of a request latches and is acknowledged.
module intc
    import intc_pkg::*;
#(
    parameter int unsigned NUM_SRC = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [15:0]        a,
    input  logic [7:0]         din,
    output logic [7:0]         dout,
    input  logic               rd,
    input  logic               wr,
    input  logic [NUM_SRC-1:0] int_req,
    output logic [NUM_SRC-1:0] int_ack,
    output logic               cpu_int_req,
    output logic [7:0]         cpu_int_vec,
    input  logic               cpu_int_ack
);

    localparam int unsigned IdxW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0] if_q, if_d;
    logic [7:0]         ie_q, ie_d;
    logic [NUM_SRC-1:0] int_ack_q;
    logic [NUM_SRC-1:0] latch;
    logic [NUM_SRC-1:0] pend;
    logic               if_wr, ie_wr, ack_clear;
    logic               enc_valid;
    logic [IdxW-1:0]    enc_idx;
    logic [7:0]         enc_vec;
    intc_state_t        state_q;
    logic               cpu_int_req_q;
    logic [7:0]         vec_hold_q;

`ifdef INTC_EDGE_DETECT_EN
    logic [NUM_SRC-1:0] req_hist_q;

    // Request history for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) req_hist_q <= '0;
        else        req_hist_q <= int_req;
    end

    assign latch = int_req & ~req_hist_q;
`else
    assign latch = int_req;
`endif

    assign if_wr     = wr && (a == INTC_ADDR_IF);
    assign ie_wr     = wr && (a == INTC_ADDR_IE);
    assign pend      = if_q & ie_q[NUM_SRC-1:0];
    assign ack_clear = (state_q == StPend) && enc_valid && cpu_int_ack;

    intc_prio_enc #(
        .NUM_SRC (NUM_SRC)
    ) u_prio_enc (
        .pend  (pend),
        .valid (enc_valid),
        .idx   (enc_idx),
        .vec   (enc_vec)
    );

    // IF update order: CPU write, then acknowledge clear, then peripheral sets.
    always_comb begin
        if_d = if_q;
        if (if_wr) begin
            if_d = din[NUM_SRC-1:0];
        end
        if (ack_clear) begin
            if_d[enc_idx] = 1'b0;
        end
        if_d = if_d | latch;
        ie_d = ie_wr ? din : ie_q;
    end

    // IF, IE and the one-cycle peripheral acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_q      <= '0;
            ie_q      <= '0;
            int_ack_q <= '0;
        end else begin
            if_q      <= if_d;
            ie_q      <= ie_d;
            int_ack_q <= latch;
        end
    end

    // Service FSM; vec_hold_q keeps the last winner shown while in PEND.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            cpu_int_req_q <= 1'b0;
            vec_hold_q    <= 8'h00;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (enc_valid) begin
                        state_q       <= StPend;
                        cpu_int_req_q <= 1'b1;
                    end
                end
                StPend: begin
                    if (enc_valid) begin
                        vec_hold_q <= enc_vec;
                    end
                    if (!enc_valid) begin
                        state_q       <= StIdle;
                        cpu_int_req_q <= 1'b0;
                    end else if (cpu_int_ack) begin
                        state_q       <= StAck;
                        cpu_int_req_q <= 1'b0;
                    end
                end
                StAck: begin
                    state_q       <= StIdle;
                    cpu_int_req_q <= 1'b0;
                end
                default: begin
                    state_q       <= StIdle;
                    cpu_int_req_q <= 1'b0;
                end
            endcase
        end
    end

    // Register read-back; unimplemented IF bits read as 1.
    always_comb begin
        dout = 8'hFF;
        if (rd && (a == INTC_ADDR_IF)) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                dout[i] = if_q[i];
            end
        end else if (rd && (a == INTC_ADDR_IE)) begin
            dout = ie_q;
        end
    end

    assign int_ack     = int_ack_q;
    assign cpu_int_req = cpu_int_req_q;
    // Live winner while pending so a higher-priority arrival pre-empts at once.
    assign cpu_int_vec = ((state_q == StPend) && enc_valid) ? enc_vec : vec_hold_q;

endmodule

// File: tb/tb_intc.sv
// Directed bench for intc (default build: level-sensitive request latching).
module tb_intc;
    import intc_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        rd;
    logic        wr;
    logic [4:0]  int_req;
    logic [4:0]  int_ack;
    logic        cpu_int_req;
    logic [7:0]  cpu_int_vec;
    logic        cpu_int_ack;

    int n_tests = 0;
    int n_fail  = 0;

    intc #(
        .NUM_SRC (5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a           (a),
        .din         (din),
        .dout        (dout),
        .rd          (rd),
        .wr          (wr),
        .int_req     (int_req),
        .int_ack     (int_ack),
        .cpu_int_req (cpu_int_req),
        .cpu_int_vec (cpu_int_vec),
        .cpu_int_ack (cpu_int_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [15:0] addr, input logic [7:0] data);
        a   = addr;
        din = data;
        wr  = 1'b1;
        tick();
        wr  = 1'b0;
    endtask

    task automatic cpu_read(input logic [15:0] addr, output logic [7:0] data);
        a  = addr;
        rd = 1'b1;
        #1;
        data = dout;
        rd = 1'b0;
    endtask

    task automatic cpu_accept();
        cpu_int_ack = 1'b1;
        tick();
        cpu_int_ack = 1'b0;
    endtask

    logic [7:0] rdata;

    initial begin
        rst_n       = 1'b0;
        a           = 16'h0000;
        din         = 8'h00;
        rd          = 1'b0;
        wr          = 1'b0;
        int_req     = '0;
        cpu_int_ack = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        check("rst_req", cpu_int_req, 1'b0);
        check("rst_vec", cpu_int_vec, 8'h00);
        check("rst_ack", int_ack, 5'b00000);
        cpu_read(INTC_ADDR_IF, rdata);
        check("rst_if", rdata, 8'hE0);
        cpu_read(INTC_ADDR_IE, rdata);
        check("rst_ie", rdata, 8'h00);

        // Timer service
        cpu_write(INTC_ADDR_IE, 8'h04);
        int_req = 5'b00100;
        tick();
        int_req = '0;
        check("tmr_ack_pulse", int_ack, 5'b00100);
        check("tmr_req_early", cpu_int_req, 1'b0);
        tick();
        check("tmr_ack_done", int_ack, 5'b00000);
        check("tmr_req", cpu_int_req, 1'b1);
        check("tmr_vec", cpu_int_vec, 8'h50);
        cpu_accept();
        check("tmr_req_in_ack", cpu_int_req, 1'b0);
        check("tmr_vec_hold", cpu_int_vec, 8'h50);
        cpu_read(INTC_ADDR_IF, rdata);
        check("tmr_if", rdata, 8'hE0);
        tick();

        // Priority
        cpu_write(INTC_ADDR_IE, 8'h1F);
        int_req = 5'b10010;
        tick();
        int_req = '0;
        tick();
        check("pri_vec", cpu_int_vec, 8'h48);
        cpu_accept();
        cpu_read(INTC_ADDR_IF, rdata);
        check("pri_if", rdata, 8'hF0);
        tick();
        tick();
        check("pri_req2", cpu_int_req, 1'b1);
        check("pri_vec2", cpu_int_vec, 8'h60);

        // Pre-emption
        int_req = 5'b00001;
        tick();
        int_req = '0;
        check("pre_vec", cpu_int_vec, 8'h40);
        check("pre_req", cpu_int_req, 1'b1);
        cpu_accept();
        cpu_read(INTC_ADDR_IF, rdata);
        check("pre_if", rdata, 8'hF0);
        tick();
        tick();
        check("pre_vec_rest", cpu_int_vec, 8'h60);
        cpu_accept();
        tick();
        cpu_read(INTC_ADDR_IF, rdata);
        check("pre_if_clear", rdata, 8'hE0);

        // Collision: peripheral set beats CPU write of 0
        a       = INTC_ADDR_IF;
        din     = 8'h00;
        wr      = 1'b1;
        int_req = 5'b01000;
        tick();
        wr      = 1'b0;
        int_req = '0;
        cpu_read(INTC_ADDR_IF, rdata);
        check("col_if", rdata, 8'hE8);
        // Clearing IF just as PEND is entered drops the request one edge later
        cpu_write(INTC_ADDR_IF, 8'h00);
        check("col_req_pend", cpu_int_req, 1'b1);
        tick();
        check("col_req_drop", cpu_int_req, 1'b0);

        // Masking
        cpu_write(INTC_ADDR_IE, 8'h00);
        cpu_write(INTC_ADDR_IF, 8'h1F);
        tick();
        tick();
        check("msk_req", cpu_int_req, 1'b0);
        cpu_read(INTC_ADDR_IF, rdata);
        check("msk_if", rdata, 8'hFF);
        cpu_write(INTC_ADDR_IE, 8'h02);
        cpu_read(INTC_ADDR_IE, rdata);
        check("msk_ie", rdata, 8'h02);
        tick();
        check("msk_req_on", cpu_int_req, 1'b1);
        check("msk_vec", cpu_int_vec, 8'h48);

        // Reset mid-flight
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_req", cpu_int_req, 1'b0);
        check("mid_vec", cpu_int_vec, 8'h00);
        cpu_read(INTC_ADDR_IF, rdata);
        check("mid_if", rdata, 8'hE0);
        cpu_read(INTC_ADDR_IE, rdata);
        check("mid_ie", rdata, 8'h00);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_req", cpu_int_req, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/intc.md
# intc

Interrupt controller for the VerilogBoy SoC, receiving the request/acknowledge handshakes that peripherals (timer, serial, joypad, LCD STAT, VBlank) initiate. It maintains IF (0xFF0F) and IE (0xFFFF), prioritises pending sources, and presents a single request plus a vector to the CPU core. On CPU acknowledge it clears the serviced IF bit.

## Interface
- `NUM_SRC`, default 5: number of interrupt sources. Bit 0 is VBlank and has the highest priority. Bit 2 is the timer.
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `a`  in  16  CPU address bus
- `din`  in  8  CPU write data
- `dout`  out  8  read data: combinational, 0xFF when not addressed
- `rd`  in  1  read strobe
- `wr`  in  1  write strobe
- `int_req`  in  NUM_SRC  peripheral requests; each is held high until acknowledged
- `int_ack`  out  NUM_SRC  one-cycle pulse per source once its request is latched into IF
- `cpu_int_req`  out  1  registered; high while the controller is in state PEND
- `cpu_int_vec`  out  8  vector of the highest-priority pending source: 0x40, 0x48, 0x50, 0x58, 0x60
- `cpu_int_ack`  in  1  CPU accepts the interrupt; sampled only in PEND

## Operation
- **Register map**
  - IF at 0xFF0F: bits [4:0] are R/W; bits [7:5] read as 1.
  - IE at 0xFFFF: all 8 bits R/W; only [4:0] take part in arbitration.
- **Latching a request:** a latch event on `int_req[i]` sets `IF[i]`. The next cycle `int_ack[i]` pulses.
- **Pending set:** `pend = IF[4:0] & IE[4:0]`. The winner is the lowest set index. The vector is `0x40 + 8*idx`.
- **FSM:** IDLE → PEND → ACK → IDLE.
  - IDLE → PEND when `pend != 0`.
  - PEND → IDLE if `pend` becomes 0 through an IF/IE write; `cpu_int_req` drops.
  - PEND → ACK on `cpu_int_ack`. At that edge, `IF[idx]` is cleared, and `idx` is the winner shown during that same cycle.
  - ACK → IDLE unconditionally. `cpu_int_req` is low for this cycle.
- **Vector tracking:** in PEND, `cpu_int_vec` tracks the current winner every cycle, so a higher-priority arrival pre-empts before the acknowledge. In IDLE and ACK it holds its last value.
- **Ignored acknowledge:** `cpu_int_ack` outside PEND is ignored.
- **Simultaneous events on one IF bit** (same edge):
  - Peripheral set beats a CPU write of 0.
  - Peripheral set beats an acknowledge clear.
  - A CPU write of 1 to IF sets the bit, which is how software triggers an interrupt.
- **IF write during acknowledge:** a CPU write to IF in the same edge as an acknowledge clear applies the write value, then the acknowledge clear, then the peripheral sets.
- **Reset:** IF = 0, IE = 0, state IDLE, `cpu_int_req` = 0, `cpu_int_vec` = 0x00, `int_ack` = 0, edge history = 0. An acknowledge in flight is discarded.

## Timing
- `int_req` edge sampled at edge N:
  - `IF` bit set after N.
  - `int_ack` high during cycle N+1.
  - `cpu_int_req` high after N+1, provided the IE bit is set.
- Read data is combinational from the current registers. A write is visible on `dout` the cycle after the write edge.
- Minimum spacing between two CPU services is 3 cycles (PEND → ACK → IDLE → PEND).
- IE being cleared while in PEND drops `cpu_int_req` after one edge.

## Configuration
- `INTC_EDGE_DETECT_EN` defined:
  - The latch event is a 0→1 transition of `int_req[i]`, using a registered history.
  - A request held high latches once.
- `INTC_EDGE_DETECT_EN` undefined:
  - The latch event is every cycle `int_req[i]` is high.
  - `int_ack[i]` pulses on each such cycle.
  - Peripherals are expected to drop the request on the first acknowledge.

## Structure
- `intc_pkg`:
  - addresses `INTC_ADDR_IF` and `INTC_ADDR_IE`
  - source index constants `SRC_VBLANK`, `SRC_STAT`, `SRC_TIMER`, `SRC_SERIAL`, `SRC_JOYPAD`
  - vector base 0x40 and stride 8
  - FSM state enum `intc_state_t`
- Sub-module `intc_prio_enc`: NUM_SRC-bit pending vector in; `valid`, `idx` and `vec` out; combinational.

## Test plan
- **Timer service:** reset, IE = 0x04, pulse `int_req[2]` → `int_ack[2]` in the next cycle. Then `cpu_int_req` = 1 with vec 0x50. `cpu_int_ack` → IF reads 0xE0.
- **Priority:** IE = 0x1F, raise requests 4 and 1 together → vec 0x48. Acknowledge → IF = 0xF0 and the next vec is 0x60.
- **Pre-emption:** IE = 0x1F, in PEND with vec 0x60, raise `int_req[0]` → vec becomes 0x40 before the acknowledge. The acknowledge clears bit 0 only.
- **Collision:** write IF = 0x00 on the same edge as a `int_req[3]` latch → IF reads 0xE8.
- **Masking:** IE = 0x00, IF = 0x1F → `cpu_int_req` stays 0. Then write IE = 0x02 → request with vec 0x48.
- **Reset mid-flight:** assert `rst_n` = 0 while in PEND → `cpu_int_req` = 0 immediately. IF and IE read 0xE0 and 0x00.
